// File: rtl/reservation_station_if.sv
// Rename-side dispatch, CDB snoop and execute-side issue signals of the reservation station.
interface reservation_station_if #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Both handshakes: a transfer occurs on the rising edge where valid && ready are both 1.
    // The producer holds its payload stable while valid is high and ready is low.
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [PREG_W-1:0] in_ps1;
    logic [PREG_W-1:0] in_ps2;
    logic [PREG_W-1:0] in_pd;
    logic [31:0]       in_instr;
    logic              in_rdy1;
    logic              in_rdy2;

    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_tag;

    logic              iss_valid;
    logic              iss_ready;
    logic [6:0]        iss_opcode;
    logic [PREG_W-1:0] iss_ps1;
    logic [PREG_W-1:0] iss_ps2;
    logic [PREG_W-1:0] iss_pd;
    logic [31:0]       iss_instr;

    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_opcode, in_ps1, in_ps2, in_pd, in_instr, in_rdy1, in_rdy2,
        output cdb_valid, cdb_tag, iss_ready,
        input  in_ready, iss_valid, iss_opcode, iss_ps1, iss_ps2, iss_pd, iss_instr, count
    );

    modport slave (
        input  in_valid, in_opcode, in_ps1, in_ps2, in_pd, in_instr, in_rdy1, in_rdy2,
        input  cdb_valid, cdb_tag, iss_ready,
        output in_ready, iss_valid, iss_opcode, iss_ps1, iss_ps2, iss_pd, iss_instr, count
    );
endinterface

// File: rtl/reservation_station.sv
// Single issue queue: holds renamed micro-ops until both sources are ready, issues lowest index first.
// Optional RS_CDB_FWD_EN: select also sees the same-cycle CDB tag, waking an entry one cycle earlier.
module reservation_station #(
    parameter  int DEPTH  = 16,
    parameter  int PREG_W = 6,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input logic                clk,
    input logic                rst_n,
    reservation_station_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  rdy1_q;
    logic [DEPTH-1:0]  rdy2_q;
    logic [6:0]        opcode_q [DEPTH];
    logic [PREG_W-1:0] ps1_q    [DEPTH];
    logic [PREG_W-1:0] ps2_q    [DEPTH];
    logic [PREG_W-1:0] pd_q     [DEPTH];
    logic [31:0]       instr_q  [DEPTH];

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_n;
    logic              in_ready_q;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [DEPTH-1:0]  issuable;
    logic              do_disp;
    logic              do_iss;
    logic              disp_rdy1;
    logic              disp_rdy2;
    logic              src2_is_imm;

    // Per-entry readiness as seen by select.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_CDB_FWD_EN
            issuable[i] = valid_q[i]
                        & (rdy1_q[i] | (rs.cdb_valid && rs.cdb_tag == ps1_q[i]))
                        & (rdy2_q[i] | (rs.cdb_valid && rs.cdb_tag == ps2_q[i]));
`else
            issuable[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i];
`endif
        end
    end

    // Descending scans so the last hit, i.e. the lowest index, wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (issuable[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign do_disp     = rs.in_valid && in_ready_q && free_found;
    assign do_iss      = sel_found && rs.iss_ready;
    assign src2_is_imm = (rs.in_opcode == 7'b0010011) || (rs.in_opcode == 7'b0000011);
    assign disp_rdy1   = rs.in_rdy1 || (rs.cdb_valid && rs.cdb_tag == rs.in_ps1);
    assign disp_rdy2   = rs.in_rdy2 || src2_is_imm || (rs.cdb_valid && rs.cdb_tag == rs.in_ps2);

    always_comb begin
        count_n = count_q;
        if (do_disp && !do_iss) begin
            count_n = count_q + CNT_W'(1);
        end else if (!do_disp && do_iss) begin
            count_n = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_n;
            in_ready_q <= (count_n < CNT_W'(DEPTH));
        end
    end

    // Issue clears, dispatch writes a free slot, otherwise valid entries snoop the CDB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_q[i] <= '0;
                ps1_q[i]    <= '0;
                ps2_q[i]    <= '0;
                pd_q[i]     <= '0;
                instr_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_iss && sel_idx == IDX_W'(i)) begin
                    valid_q[i] <= 1'b0;
                    rdy1_q[i]  <= 1'b0;
                    rdy2_q[i]  <= 1'b0;
                end else if (do_disp && free_idx == IDX_W'(i)) begin
                    valid_q[i]  <= 1'b1;
                    rdy1_q[i]   <= disp_rdy1;
                    rdy2_q[i]   <= disp_rdy2;
                    opcode_q[i] <= rs.in_opcode;
                    ps1_q[i]    <= rs.in_ps1;
                    ps2_q[i]    <= rs.in_ps2;
                    pd_q[i]     <= rs.in_pd;
                    instr_q[i]  <= rs.in_instr;
                end else if (valid_q[i] && rs.cdb_valid) begin
                    if (rs.cdb_tag == ps1_q[i]) rdy1_q[i] <= 1'b1;
                    if (rs.cdb_tag == ps2_q[i]) rdy2_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rs.iss_valid  = sel_found;
        rs.iss_opcode = '0;
        rs.iss_ps1    = '0;
        rs.iss_ps2    = '0;
        rs.iss_pd     = '0;
        rs.iss_instr  = '0;
        if (sel_found) begin
            rs.iss_opcode = opcode_q[sel_idx];
            rs.iss_ps1    = ps1_q[sel_idx];
            rs.iss_ps2    = ps2_q[sel_idx];
            rs.iss_pd     = pd_q[sel_idx];
            rs.iss_instr  = instr_q[sel_idx];
        end
    end

    assign rs.in_ready = in_ready_q;
    assign rs.count    = count_q;
endmodule
